mul_sequencer: RTL and testbench

//  Iterative multi-cycle multiplier/accumulator for the Execute stage. It performs
//  MUL (a*b) and MLA (a*b+c) by shift-add over several cycles, so the single-cycle
//  ALU multiplier is removed from the critical path.

---
 rtl/mul_sequencer.sv | 115 +++++++++++
 tb/tb_mul_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_sequencer.sv
// mul_sequencer: iterative shift-add MUL/MLA for Execute, stalling the pipeline while busy.
// Retires BITS_PER_CYCLE multiplier bits per cycle; MLA adds c in one extra cycle.
module mul_sequencer #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_mla,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       flags
);
    localparam int N_ITER = WIDTH / BITS_PER_CYCLE;
    localparam int CW     = N_ITER > 1 ? $clog2(N_ITER) : 1;

    typedef enum logic [1:0] {IDLE, RUN, ACC, DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_c, r_acc, r_result, w_pp, w_res_next;
    logic [CW-1:0]    r_count;
    logic [1:0]       r_flags;
    logic             r_mla, r_busy, r_done, w_accept, w_last, w_load;

    assign w_accept = start & ~flush & (r_state == IDLE || r_state == DONE);
    assign w_last   = r_state == RUN && r_count == CW'(N_ITER - 1);
    // Stall is gated by reset so every output reads 0 while reset is held.
    assign stall    = reset & (w_accept | r_busy);
    assign busy     = r_busy;
    assign done     = r_done;
    assign result   = r_result;
    assign flags    = r_flags;

    always_comb begin
        w_pp = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++)
            if (r_b[i]) w_pp = w_pp + (r_a << i);
    end

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_res_next = r_result;
        case (r_state)
            IDLE, DONE: w_next = w_accept ? RUN : IDLE;
            RUN: begin
                if (w_last) begin
                    w_next     = r_mla ? ACC : DONE;
                    w_load     = 1'b1;
                    w_res_next = r_acc + w_pp;
                end
            end
            ACC: begin
                w_next     = DONE;
                w_load     = 1'b1;
                w_res_next = r_result + r_c;
            end
            default: w_next = IDLE;
        endcase
        if (flush) begin
            w_next = IDLE;
            w_load = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= w_next == RUN || w_next == ACC;
            r_done  <= w_next == DONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= '0;
            r_mla    <= 1'b0;
            r_acc    <= '0;
            r_count  <= '0;
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            if (w_accept) begin
                r_a     <= a;
                r_b     <= b;
                r_c     <= c;
                r_mla   <= op_mla;
                r_acc   <= '0;
                r_count <= '0;
            end else if (r_state == RUN) begin
                r_acc   <= r_acc + w_pp;
                r_a     <= r_a << BITS_PER_CYCLE;
                r_b     <= r_b >> BITS_PER_CYCLE;
                r_count <= r_count + CW'(1);
            end
            if (w_load) begin
                r_result <= w_res_next;
                r_flags  <= {w_res_next[WIDTH-1], w_res_next == '0};
            end
        end
    end
endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: vector table + hand sequences on three instances (2, 1 and 4 bits per cycle).
// Expected results and done cycles are queued per instance at accept and matched on done.
module tb_mul_sequencer;
    localparam int BPCS [3] = '{2, 1, 4};

    typedef struct {
        logic        mla;
        logic [31:0] a, b, c, r;
        logic [1:0]  f;
    } vec_t;

    typedef struct {
        logic [31:0] r;
        logic [1:0]  f;
        int          cyc;
    } exp_t;

    logic        clk = 0, rst_n = 0, op_mla = 0, flush = 0;
    logic [31:0] a = 0, b = 0, c = 0;
    logic        start_v [3];
    logic        stall_v [3], busy_v [3], done_v [3];
    logic [31:0] result_v [3];
    logic [1:0]  flags_v [3];
    exp_t        sb [3][$];
    exp_t        e;
    int          cyc = 0, checks = 0, failures = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mul_sequencer #(.WIDTH(32), .BITS_PER_CYCLE(BPCS[g])) u_dut (
            .clk(clk), .reset(rst_n), .start(start_v[g]), .op_mla(op_mla),
            .a(a), .b(b), .c(c), .flush(flush),
            .stall(stall_v[g]), .busy(busy_v[g]), .done(done_v[g]),
            .result(result_v[g]), .flags(flags_v[g])
        );
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [2:0] mask, input logic m, input logic [31:0] r,
                            input logic [1:0] f, input int acc);
        for (int k = 0; k < 3; k++)
            if (mask[k]) sb[k].push_back('{r, f, acc + 32 / BPCS[k] + 1 + int'(m)});
    endtask

    always @(negedge clk)
        for (int k = 0; k < 3; k++)
            if (done_v[k]) begin
                if (sb[k].size() == 0) chk($sformatf("spurious_done%0d", k), 32'(done_v[k]), 0);
                else begin
                    e = sb[k].pop_front();
                    chk($sformatf("result%0d", k), result_v[k], e.r);
                    chk($sformatf("flags%0d", k), 32'(flags_v[k]), 32'(e.f));
                    chk($sformatf("latency%0d", k), cyc, e.cyc);
                end
            end

    task automatic wait_idle(input int bound);
        int n = 0;
        while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb[0].size() + sb[1].size() + sb[2].size(), 0);
    endtask

    task automatic run_op(input logic [2:0] mask, input logic m, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] z,
                          input logic [31:0] r, input logic [1:0] f);
        bit ok = 1;
        tick();
        a = x; b = y; c = z; op_mla = m;
        for (int k = 0; k < 3; k++) start_v[k] = mask[k];
        push_exp(mask, m, r, f, cyc);
        @(negedge clk);
        if (!stall_v[0]) ok = 0;
        tick();
        for (int k = 0; k < 3; k++) start_v[k] = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done_v[0]) break;
            if (!(stall_v[0] && busy_v[0])) ok = 0;
        end
        chk("done_seen", 32'(done_v[0]), 1);
        chk("stall_window", 32'(ok), 1);
        chk("stall_at_done", 32'({stall_v[0], busy_v[0]}), 0);
        wait_idle(80);
    endtask

    vec_t vt [7];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, d;
        bit ok;
        logic        m;
        logic [31:0] x, y, z, r;
        for (int k = 0; k < 3; k++) start_v[k] = 0;
        vt[0] = '{0, 32'd7, 32'd6, 32'd0, 32'd42, 2'b00};
        vt[1] = '{1, 32'd3, 32'd5, 32'hFFFF_FFF1, 32'd0, 2'b01};
        vt[2] = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 2'b00};
        vt[3] = '{0, 32'h8000_0000, 32'd1, 32'd0, 32'h8000_0000, 2'b10};
        vt[4] = '{1, 32'd0, 32'd0, 32'd0, 32'd0, 2'b01};
        vt[5] = '{0, 32'h1234_5678, 32'd16, 32'd0, 32'h2345_6780, 2'b00};
        vt[6] = '{1, 32'h0000_FFFF, 32'h0000_FFFF, 32'd1, 32'hFFFE_0002, 2'b10};

        tick(); tick();
        @(negedge clk);
        chk("rst_stall", 32'(stall_v[0]), 0);
        chk("rst_busy", 32'(busy_v[0]), 0);
        chk("rst_done", 32'(done_v[0]), 0);
        chk("rst_result", result_v[0], 0);
        chk("rst_flags", 32'(flags_v[0]), 0);
        rst_n = 1;

        foreach (vt[i]) run_op(3'b111, vt[i].mla, vt[i].a, vt[i].b, vt[i].c, vt[i].r, vt[i].f);

        // back-to-back: start held through done with new operands
        tick();
        a = 2; b = 3; op_mla = 0; start_v[0] = 1;
        push_exp(3'b001, 0, 6, 2'b00, cyc);
        d = -1;
        for (int n = 0; n < 40 && d < 0; n++) begin
            @(negedge clk);
            if (done_v[0]) d = cyc;
        end
        chk("b2b_first_done", 32'(d >= 0), 1);
        chk("b2b_stall_in_done", 32'(stall_v[0]), 1);
        a = 4; b = 5;
        push_exp(3'b001, 0, 20, 2'b00, cyc);
        tick();
        start_v[0] = 0;
        ok = 1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (result_v[0] !== 32'd6) ok = 0;
        end
        chk("b2b_result_held", 32'(ok), 1);
        wait_idle(40);

        // flush in cycle 8 of a MUL
        tick();
        a = 9; b = 9; start_v[0] = 1; s = cyc;
        tick();
        start_v[0] = 0;
        while (cyc < s + 8) tick();
        flush = 1;
        @(negedge clk);
        chk("flush_c8_stall", 32'(stall_v[0]), 1);
        tick();
        flush = 0;
        @(negedge clk);
        chk("flush_c9_stall", 32'(stall_v[0]), 0);
        chk("flush_c9_busy", 32'(busy_v[0]), 0);
        repeat (25) tick();
        chk("flush_result_kept", result_v[0], 20);
        chk("flush_flags_kept", 32'(flags_v[0]), 0);

        // flush beats start
        tick();
        start_v[0] = 1; flush = 1;
        @(negedge clk);
        chk("flush_vs_start_stall", 32'(stall_v[0]), 0);
        tick();
        start_v[0] = 0; flush = 0;
        @(negedge clk);
        chk("flush_vs_start_busy", 32'(busy_v[0]), 0);
        repeat (20) tick();

        // reset mid-operation
        tick();
        a = 7; b = 6; start_v[0] = 1; s = cyc;
        tick();
        start_v[0] = 0;
        while (cyc < s + 8) tick();
        chk("pre_reset_busy", 32'(busy_v[0]), 1);
        rst_n = 0;
        #1;
        chk("mid_rst_stall", 32'(stall_v[0]), 0);
        chk("mid_rst_busy", 32'(busy_v[0]), 0);
        chk("mid_rst_done", 32'(done_v[0]), 0);
        chk("mid_rst_result", result_v[0], 0);
        chk("mid_rst_flags", 32'(flags_v[0]), 0);
        @(negedge clk);
        rst_n = 1;
        repeat (25) tick();
        chk("post_rst_result", result_v[0], 0);

        for (int i = 0; i < 1000; i++) begin
            m = 1'($urandom_range(0, 1));
            x = $urandom; y = $urandom; z = $urandom;
            r = m ? x * y + z : x * y;
            run_op(3'b111, m, x, y, z, r, {r[31], r == 0});
        end

        repeat (5) tick();
        chk("final_queues", sb[0].size() + sb[1].size() + sb[2].size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
